dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back data cache controller with per-line dirty bits.
- Acts as the responder for the CPU MEM stage memory requests (read, write, address, write data); returns read data and a stall.
- Acts as the initiator toward the line-wide backing memory.
- Sits between the MEM stage and data memory. The CPU freezes its pipeline while cpu_stall is high.

Parameters:
- INDEX_W, 3: index bits; number of lines = 2**INDEX_W.
- Fixed, not parameters: 4 words/line, 16-bit words, 16-bit word address, offset = addr[1:0], index = addr[2+INDEX_W-1:2], tag = addr[15:2+INDEX_W].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_rd  in  1  MEM-stage load request.
- cpu_wr  in  1  MEM-stage store request.
- cpu_addr  in  16  word address.
- cpu_wdata  in  16  store data.
- cpu_rdata  out  16  load data; valid in the hit cycle.
- cpu_stall  out  1  request not yet complete; CPU holds the request stable.
- mem_rd  out  1  line fill request.
- mem_wr  out  1  line writeback request.
- mem_addr  out  14  line address {tag,index}.
- mem_wdata  out  64  victim line; word 0 in [15:0].
- mem_rdata  in  64  fill line; valid when mem_rdy=1.
- mem_rdy  in  1  one-cycle completion pulse from memory.

Behaviour:
- Storage: per line data[64], tag, valid, dirty. Reset clears all valid and dirty bits. Data and tag contents are not cleared.
- Request: req = cpu_rd | cpu_wr. If both are high, the request is treated as a write.
- hit = valid[index] & (tag[index] == addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no req:
  - cpu_stall=0, cpu_rdata=0, mem_rd=mem_wr=0.
- IDLE, req & hit (zero-latency hit):
  - cpu_stall=0.
  - Read: cpu_rdata = selected word, combinational, same cycle.
  - Write: word updated and dirty set at the clock edge; cpu_rdata=0.
- IDLE, req & miss:
  - cpu_stall=1 combinationally in the same cycle.
  - Next state is WRITEBACK if the victim is valid and dirty, else ALLOCATE.
  - No array update.
- WRITEBACK:
  - mem_wr=1, mem_addr={victim tag,index}, mem_wdata=victim line, cpu_stall=1.
  - Outputs are held until mem_rdy.
  - On mem_rdy: clear dirty, go to ALLOCATE.
- ALLOCATE:
  - mem_rd=1, mem_addr={req tag,index}, cpu_stall=1.
  - On mem_rdy: line=mem_rdata, tag=req tag, valid=1, dirty=0, go to IDLE.
- Completing a miss: the following IDLE cycle hits and completes the access (write merge or read return) with cpu_stall=0.
- Miss latency: total stall cycles = 1 + (writeback wait) + (fill wait).
- mem_rd and mem_wr are never high together. Each drops in the cycle after its mem_rdy.
- mem_rdy outside WRITEBACK/ALLOCATE is ignored.
- Request change while stalled: illegal. The controller services the address latched at miss detection (req_addr register). The final hit check uses the live cpu_addr.
- Request withdrawn while stalled: the fill or writeback still completes, then the FSM returns to IDLE with no CPU-side effect.
- Reset mid-operation: FSM goes to IDLE. mem_rd and mem_wr are 0 from the cycle after the reset edge; during rst=1, all outputs are 0. Dirty data in flight is lost; this is accepted.
- Reset values: cpu_rdata=0, cpu_stall=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.

Optional Feature:
- DCACHE_STATS_EN: adds ports hit_cnt out 16 and miss_cnt out 16.
- hit_cnt increments on each completed hit access, excluding the post-fill completion cycle.
- miss_cnt increments once per miss detection in IDLE.
- Both counters saturate at 16'hFFFF and reset to 0.
- Without the macro: no ports and no counter logic; behaviour is otherwise identical.

Test Plan:
- Cold read miss: rst, then cpu_rd addr=16'h0010, memory returns 64'h0004_0003_0002_0001 after 3 cycles.
  - Expect mem_rd with mem_addr=14'h0004 and no mem_wr.
  - Stall ends with cpu_rdata=16'h0001.
- Read hit: after the fill, cpu_rd addr=16'h0012.
  - Expect cpu_rdata=16'h0003 and cpu_stall=0 in the same cycle, no mem activity.
- Write hit then dirty eviction:
  - cpu_wr addr=16'h0011 data=16'hBEEF hits.
  - Then cpu_rd addr=16'h0030 (same index, new tag): mem_wr first with mem_addr=14'h0004 and mem_wdata=64'h0004_0003_BEEF_0001, then mem_rd with mem_addr=14'h000C.
- Clean eviction: same index after the fill, with no write.
  - Expect mem_rd only, no mem_wr.
- Write miss allocate: cpu_wr addr=16'h0045 data=16'h1234 on a clean miss.
  - Expect a fill, then the word merged.
  - A subsequent read of 16'h0045 returns 16'h1234 with the line dirty.
- Reset in ALLOCATE: assert rst while mem_rd=1.
  - Expect mem_rd=0 from the next cycle and cpu_stall=0.
  - Re-reading the same address misses again.
  - With DCACHE_STATS_EN: counters read 0, then increment to miss_cnt=1.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: zero-latency hits, line fill / victim writeback FSM.
// Optional hit/miss statistics counters are enabled with `define DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int INDEX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [13:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rdy
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 14 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic [63:0]      data_r [LINES];
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [LINES-1:0] valid_r;
  logic [LINES-1:0] dirty_r;
  logic [13:0]      req_line_r;

  logic               req_s, hit_s, hit_wr_s, miss_s, wb_done_s, fill_s;
  logic [INDEX_W-1:0] idx_s, ridx_s;
  logic [TAG_W-1:0]   tag_s;
  logic [1:0]         off_s;
  logic [15:0]        word_s;

  assign req_s     = cpu_rd | cpu_wr;
  assign idx_s     = cpu_addr[2+INDEX_W-1:2];
  assign tag_s     = cpu_addr[15:2+INDEX_W];
  assign off_s     = cpu_addr[1:0];
  assign hit_s     = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign word_s    = data_r[idx_s][{off_s, 4'b0000} +: 16];
  // The miss is serviced from the line address latched at detection, not the live address.
  assign ridx_s    = req_line_r[INDEX_W-1:0];
  assign wb_done_s = (state_r == WRITEBACK) && mem_rdy;
  assign fill_s    = (state_r == ALLOCATE) && mem_rdy;

  // Next-state and output decode; everything is forced to zero while rst is high.
  always_comb begin
    state_s   = state_r;
    cpu_stall = 1'b0;
    cpu_rdata = 16'h0000;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 14'h0000;
    mem_wdata = 64'h0000_0000_0000_0000;
    hit_wr_s  = 1'b0;
    miss_s    = 1'b0;
    if (rst) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (!req_s) begin
            state_s = IDLE;
          end else if (hit_s) begin
            if (cpu_wr) begin
              hit_wr_s = 1'b1;
            end else begin
              cpu_rdata = word_s;
            end
          end else begin
            cpu_stall = 1'b1;
            miss_s    = 1'b1;
            if (valid_r[idx_s] && dirty_r[idx_s]) begin
              state_s = WRITEBACK;
            end else begin
              state_s = ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          mem_wr    = 1'b1;
          mem_addr  = {tag_r[ridx_s], ridx_s};
          mem_wdata = data_r[ridx_s];
          cpu_stall = 1'b1;
          if (mem_rdy) begin
            state_s = ALLOCATE;
          end else begin
            state_s = WRITEBACK;
          end
        end
        ALLOCATE: begin
          mem_rd    = 1'b1;
          mem_addr  = req_line_r;
          cpu_stall = 1'b1;
          if (mem_rdy) begin
            state_s = IDLE;
          end else begin
            state_s = ALLOCATE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latch the missing line address at miss detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_line_r <= 14'h0000;
    end else if (miss_s) begin
      req_line_r <= cpu_addr[15:2];
    end else begin
      req_line_r <= req_line_r;
    end
  end

  // Line storage: data and tags keep their contents across reset; valid/dirty are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else begin
      if (hit_wr_s) begin
        data_r[idx_s][{off_s, 4'b0000} +: 16] <= cpu_wdata;
        dirty_r[idx_s] <= 1'b1;
      end
      if (wb_done_s) begin
        dirty_r[ridx_s] <= 1'b0;
      end
      if (fill_s) begin
        data_r[ridx_s]  <= mem_rdata;
        tag_r[ridx_s]   <= req_line_r[13:INDEX_W];
        valid_r[ridx_s] <= 1'b1;
        dirty_r[ridx_s] <= 1'b0;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic post_fill_r;

  // Saturating counters; the hit that completes a fill is not counted as a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      post_fill_r <= 1'b0;
      hit_cnt     <= 16'h0000;
      miss_cnt    <= 16'h0000;
    end else begin
      post_fill_r <= fill_s;
      if ((state_r == IDLE) && req_s && hit_s && !post_fill_r && (hit_cnt != 16'hFFFF)) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
      if (miss_s && (miss_cnt != 16'hFFFF)) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a memory responder with a transaction scoreboard
// plus a CPU-side queue of expected load results.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [15:0] cpu_wdata = 16'h0000;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_rd;
  logic        mem_wr;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_rdy;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int mem_lat = 3;

  typedef struct {
    logic        is_wr;
    logic [13:0] addr;
    logic [63:0] wdata;
  } mem_txn_t;

  mem_txn_t    mem_q[$];
  logic [15:0] cpu_q[$];
  logic [63:0] mem_model [logic [13:0]];

  dcache_ctrl #(.INDEX_W(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
`ifdef DCACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Backing store: unwritten lines hold their own word addresses.
  function automatic logic [63:0] model_line(input logic [13:0] a);
    logic [15:0] w0;
    w0 = {a, 2'b00};
    if (mem_model.exists(a)) return mem_model[a];
    return {w0 + 16'd3, w0 + 16'd2, w0 + 16'd1, w0};
  endfunction

  function automatic mem_txn_t txn(input logic is_wr, input logic [13:0] a, input logic [63:0] d);
    mem_txn_t t;
    t.is_wr = is_wr;
    t.addr  = a;
    t.wdata = d;
    return t;
  endfunction

  // Memory responder: checks each new request against the scoreboard, answers after mem_lat cycles.
  initial begin : responder
    int cnt;
    bit busy;
    mem_txn_t t;
    mem_rdy = 1'b0;
    mem_rdata = 64'h0;
    cnt = 0;
    busy = 1'b0;
    forever begin
      @(negedge clk);
      mem_rdy = 1'b0;
      if (rst || !(mem_rd || mem_wr)) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt = 0;
          checks++;
          if ((mem_rd & mem_wr) !== 1'b0) begin
            failures++;
            $display("FAIL mem_exclusive: mem_rd=%b mem_wr=%b, required not both high", mem_rd, mem_wr);
          end
          checks++;
          if (mem_q.size() == 0) begin
            failures++;
            $display("FAIL mem_unexpected: got wr=%b addr=%h, required no memory request", mem_wr, mem_addr);
          end else begin
            t = mem_q.pop_front();
            if (t.is_wr !== mem_wr || t.addr !== mem_addr || (t.is_wr && t.wdata !== mem_wdata)) begin
              failures++;
              $display("FAIL mem_txn: got wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                       mem_wr, mem_addr, mem_wdata, t.is_wr, t.addr, t.wdata);
            end
          end
        end
        cnt++;
        if (cnt >= mem_lat) begin
          mem_rdy = 1'b1;
          busy = 1'b0;
          if (mem_wr) mem_model[mem_addr] = mem_wdata;
          else mem_rdata = model_line(mem_addr);
        end
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rdata, input int exp_stalls, input string name);
    int stalls;
    logic [15:0] exp;
    @(negedge clk);
    cpu_rd = rd;
    cpu_wr = wr;
    cpu_addr = addr;
    cpu_wdata = wdata;
    cpu_q.push_back(exp_rdata);
    #1;
    stalls = 0;
    while (cpu_stall === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    exp = cpu_q.pop_front();
    checks++;
    if (cpu_stall !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout: cpu_stall=%b after %0d cycles, required 0", name, cpu_stall, stalls);
    end
    checks++;
    if (cpu_rdata !== exp) begin
      failures++;
      $display("FAIL %s_rdata: got %h, required %h", name, cpu_rdata, exp);
    end
    checks++;
    if (stalls != exp_stalls) begin
      failures++;
      $display("FAIL %s_stalls: got %0d, required %0d", name, stalls, exp_stalls);
    end
  endtask

  task automatic go_idle(input string name);
    @(negedge clk);
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    #1;
    checks++;
    if ({cpu_stall, mem_rd, mem_wr, cpu_rdata} !== 19'h0) begin
      failures++;
      $display("FAIL %s_idle: stall=%b rd=%b wr=%b rdata=%h, required all 0", name, cpu_stall, mem_rd, mem_wr, cpu_rdata);
    end
    checks++;
    if (mem_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending: %0d memory transactions not seen, required 0", name, mem_q.size());
    end
  endtask

  task automatic check_stats(input logic [15:0] exp_hit, input logic [15:0] exp_miss, input string name);
`ifdef DCACHE_STATS_EN
    checks++;
    if (hit_cnt !== exp_hit || miss_cnt !== exp_miss) begin
      failures++;
      $display("FAIL %s_stats: hit=%0d miss=%0d, required hit=%0d miss=%0d", name, hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_rd = 1'b1;
    cpu_addr = 16'h0010;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({cpu_rdata, cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata} !== 97'h0) begin
      failures++;
      $display("FAIL reset_outputs: rdata=%h stall=%b rd=%b wr=%b addr=%h wdata=%h, required all 0",
               cpu_rdata, cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    cpu_rd = 1'b0;
    #1;
    checks++;
    if ({cpu_rdata, cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata} !== 97'h0) begin
      failures++;
      $display("FAIL post_reset_idle: rdata=%h stall=%b rd=%b wr=%b, required all 0", cpu_rdata, cpu_stall, mem_rd, mem_wr);
    end
    check_stats(16'd0, 16'd0, "reset");
  endtask

  task automatic test_cold_read();
    mem_model[14'h0004] = 64'h0004_0003_0002_0001;
    mem_q.push_back(txn(1'b0, 14'h0004, 64'h0));
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0001, 4, "cold_read");
  endtask

  task automatic test_read_hit();
    access(1'b1, 1'b0, 16'h0012, 16'h0000, 16'h0003, 0, "read_hit");
    go_idle("read_hit");
  endtask

  task automatic test_dirty_evict();
    access(1'b0, 1'b1, 16'h0011, 16'hBEEF, 16'h0000, 0, "write_hit");
    mem_q.push_back(txn(1'b1, 14'h0004, 64'h0004_0003_BEEF_0001));
    mem_q.push_back(txn(1'b0, 14'h000C, 64'h0));
    access(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0030, 7, "dirty_evict");
    go_idle("dirty_evict");
  endtask

  task automatic test_clean_evict();
    mem_q.push_back(txn(1'b0, 14'h0004, 64'h0));
    access(1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF, 4, "clean_evict");
    go_idle("clean_evict");
  endtask

  task automatic test_write_miss();
    mem_q.push_back(txn(1'b0, 14'h0011, 64'h0));
    access(1'b0, 1'b1, 16'h0045, 16'h1234, 16'h0000, 4, "write_miss");
    access(1'b1, 1'b0, 16'h0045, 16'h0000, 16'h1234, 0, "write_miss_readback");
    mem_q.push_back(txn(1'b1, 14'h0011, 64'h0047_0046_1234_0044));
    mem_q.push_back(txn(1'b0, 14'h0009, 64'h0));
    access(1'b1, 1'b0, 16'h0025, 16'h0000, 16'h0025, 7, "write_miss_dirty");
    go_idle("write_miss");
  endtask

  task automatic test_back_to_back();
    access(1'b1, 1'b0, 16'h0024, 16'h0000, 16'h0024, 0, "b2b_rd0");
    access(1'b0, 1'b1, 16'h0026, 16'h5555, 16'h0000, 0, "b2b_wr");
    access(1'b1, 1'b0, 16'h0026, 16'h0000, 16'h5555, 0, "b2b_rd1");
    access(1'b1, 1'b0, 16'h0027, 16'h0000, 16'h0027, 0, "b2b_rd2");
    go_idle("b2b");
  endtask

  task automatic test_reset_alloc();
    int n;
    mem_lat = 20;
    mem_q.push_back(txn(1'b0, 14'h0014, 64'h0));
    @(negedge clk);
    cpu_rd = 1'b1;
    cpu_addr = 16'h0050;
    #1;
    n = 0;
    while (mem_rd !== 1'b1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (mem_rd !== 1'b1) begin
      failures++;
      $display("FAIL rst_alloc_fill: mem_rd=%b, required 1", mem_rd);
    end
    @(negedge clk);
    rst = 1'b1;
    cpu_rd = 1'b0;
    #1;
    checks++;
    if ({cpu_rdata, cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata} !== 97'h0) begin
      failures++;
      $display("FAIL rst_alloc_during: stall=%b rd=%b wr=%b addr=%h, required all 0", cpu_stall, mem_rd, mem_wr, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || cpu_stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_alloc_after: mem_rd=%b stall=%b, required 0 0", mem_rd, cpu_stall);
    end
    check_stats(16'd0, 16'd0, "rst_alloc_cleared");
    mem_lat = 3;
    mem_q.push_back(txn(1'b0, 14'h0014, 64'h0));
    access(1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0050, 4, "rst_alloc_remiss");
    go_idle("rst_alloc");
    check_stats(16'd0, 16'd1, "rst_alloc_counted");
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_read_hit();
    test_dirty_evict();
    test_clean_evict();
    test_write_miss();
    test_back_to_back();
    test_reset_alloc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
